clksel_ctrl: RTL and testbench

//  Upstream controller for the PHI2 clock switch, clocked by hsclk_in. Decodes each new CPU

---
 rtl/clksel_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_clksel_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clksel_ctrl.sv
// clksel_ctrl: upstream controller for the PHI2 clock switch.
// Decodes each CPU cycle address into a fast/slow request, drives the switch
// select lines, stalls the CPU while the switch hands over, applies a
// slow-speed hold-off after slow accesses and owns the speed config register.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_SLOW    | slow clock in use; divider select may be updated
// ST_TO_FAST | fast clock requested, CPU stalled, waiting for hs_ack
// ST_FAST    | fast clock in use
// ST_TO_SLOW | slow clock requested, CPU stalled, waiting for ls_ack
module clksel_ctrl #(
  parameter logic [23:0] SLOW_MASK   = 24'hFF0000,
  parameter logic [23:0] SLOW_MATCH  = 24'hFF0000,
  parameter logic [4:0]  HOLD_RST    = 5'd4,
  parameter logic [7:0]  TIMEOUT     = 8'd255,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        hsclk_in,
  input  logic        rst_b,
  input  logic        cyc_valid,
  input  logic [23:0] cyc_addr,
  input  logic        hsclk_selected,
  input  logic        lsclk_selected,
  input  logic        cfg_wr,
  input  logic [7:0]  cfg_wdata,
  output logic [7:0]  cfg_rdata,
  output logic        hsclk_sel,
  output logic [1:0]  cpuclk_div_sel,
  output logic        cyc_stall,
  output logic        switch_err
);

  typedef enum logic [1:0] {
    ST_SLOW    = 2'd0,
    ST_TO_FAST = 2'd1,
    ST_FAST    = 2'd2,
    ST_TO_SLOW = 2'd3
  } state_t;

  // cfg layout: [0]=fast_en [2:1]=div [7:3]=hold
  localparam logic [7:0] CFG_RST = {HOLD_RST, 2'b00, 1'b0};

  state_t                 r_state;
  logic                   r_hsclk_sel;
  logic                   r_stall;
  logic                   r_err;
  logic [7:0]             r_to_cnt;
  logic [4:0]             r_hold_cnt;
  logic [7:0]             r_cfg;
  logic [1:0]             r_div_pend;
  logic [1:0]             r_div_sel;
  logic [SYNC_STAGES-1:0] r_hs_sync;
  logic [SYNC_STAGES-1:0] r_ls_sync;

  state_t     w_state_nxt;
  logic       w_hsclk_sel_nxt;
  logic       w_stall_nxt;
  logic       w_err_set;
  logic [7:0] w_to_cnt_nxt;
  logic [4:0] w_hold_cnt_nxt;
  logic       w_hs_ack;
  logic       w_ls_ack;
  logic       w_fast_en;
  logic [4:0] w_hold_cfg;
  logic       w_slow_req;
  logic [7:0] w_to_inc;
  logic       w_timeout;

  assign w_hs_ack   = r_hs_sync[SYNC_STAGES-1];
  assign w_ls_ack   = r_ls_sync[SYNC_STAGES-1];
  assign w_fast_en  = r_cfg[0];
  assign w_hold_cfg = r_cfg[7:3];
  // Decode always uses the registered cfg, so a same-cycle write is seen next access.
  assign w_slow_req = !w_fast_en || ((cyc_addr & SLOW_MASK) == SLOW_MATCH);
  // Timeout fires on the wait cycle whose incremented count reaches TIMEOUT.
  assign w_to_inc   = r_to_cnt + 8'd1;
  assign w_timeout  = (w_to_inc == TIMEOUT);

  // Synchronise the asynchronous switch status lines into hsclk_in.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_hs_sync <= '0;
      r_ls_sync <= '0;
    end else begin
      r_hs_sync <= {r_hs_sync[SYNC_STAGES-2:0], hsclk_selected};
      r_ls_sync <= {r_ls_sync[SYNC_STAGES-2:0], lsclk_selected};
    end
  end

  // Config register, staged divider, and divider apply gated to the slow state.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_cfg      <= CFG_RST;
      r_div_pend <= 2'b00;
      r_div_sel  <= 2'b00;
    end else begin
      if (cfg_wr) begin
        r_cfg      <= cfg_wdata;
        r_div_pend <= cfg_wdata[2:1];
      end
      // Divider only moves while the fast clock is deselected.
      if (r_state == ST_SLOW) begin
        r_div_sel <= r_div_pend;
      end
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= ST_SLOW;
      r_hsclk_sel <= 1'b0;
      r_stall     <= 1'b0;
      r_err       <= 1'b0;
      r_to_cnt    <= 8'd0;
      r_hold_cnt  <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_hsclk_sel <= w_hsclk_sel_nxt;
      r_stall     <= w_stall_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      // A cfg write clears the sticky error and wins over a same-cycle set.
      if (cfg_wr) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Next-state decode, switch requests, timeout and hold-off bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_hsclk_sel_nxt = r_hsclk_sel;
    w_stall_nxt     = r_stall;
    w_to_cnt_nxt    = r_to_cnt;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_err_set       = 1'b0;
    case (r_state)
      ST_SLOW: begin
        if (cyc_valid) begin
          if (w_slow_req) begin
            w_hold_cnt_nxt = w_hold_cfg;
          end else if (r_hold_cnt != 5'd0) begin
            w_hold_cnt_nxt = r_hold_cnt - 5'd1;
          end else begin
            w_hsclk_sel_nxt = 1'b1;
            w_stall_nxt     = 1'b1;
            w_to_cnt_nxt    = 8'd0;
            w_state_nxt     = ST_TO_FAST;
          end
        end
      end
      ST_TO_FAST: begin
        if (cyc_valid) begin
          w_err_set = 1'b1;
        end
        if (w_hs_ack) begin
          w_stall_nxt = 1'b0;
          w_state_nxt = ST_FAST;
        end else if (w_timeout) begin
          w_err_set   = 1'b1;
          w_stall_nxt = 1'b0;
          w_state_nxt = ST_FAST;
        end else begin
          w_to_cnt_nxt = w_to_inc;
        end
      end
      ST_FAST: begin
        if (cyc_valid && w_slow_req) begin
          w_hsclk_sel_nxt = 1'b0;
          w_stall_nxt     = 1'b1;
          w_to_cnt_nxt    = 8'd0;
          w_hold_cnt_nxt  = w_hold_cfg;
          w_state_nxt     = ST_TO_SLOW;
        end
      end
      ST_TO_SLOW: begin
        if (cyc_valid) begin
          w_err_set = 1'b1;
        end
        if (w_ls_ack) begin
          w_stall_nxt = 1'b0;
          w_state_nxt = ST_SLOW;
        end else if (w_timeout) begin
          w_err_set   = 1'b1;
          w_stall_nxt = 1'b0;
          w_state_nxt = ST_SLOW;
        end else begin
          w_to_cnt_nxt = w_to_inc;
        end
      end
      default: begin
        w_hsclk_sel_nxt = 1'b0;
        w_stall_nxt     = 1'b0;
        w_state_nxt     = ST_SLOW;
      end
    endcase
  end

  assign cfg_rdata      = r_cfg;
  assign hsclk_sel      = r_hsclk_sel;
  assign cpuclk_div_sel = r_div_sel;
  assign cyc_stall      = r_stall;
  assign switch_err     = r_err;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Directed bench for clksel_ctrl: walks the slow/fast handover, hold-off,
// ack timeout, divider staging, same-cycle cfg write and async reset.
module tb_clksel_ctrl;

  logic        hsclk_in;
  logic        rst_b;
  logic        cyc_valid;
  logic [23:0] cyc_addr;
  logic        hsclk_selected;
  logic        lsclk_selected;
  logic        cfg_wr;
  logic [7:0]  cfg_wdata;
  logic [7:0]  cfg_rdata;
  logic        hsclk_sel;
  logic [1:0]  cpuclk_div_sel;
  logic        cyc_stall;
  logic        switch_err;

  int n_pass;
  int n_total;

  clksel_ctrl dut (
    .hsclk_in       (hsclk_in),
    .rst_b          (rst_b),
    .cyc_valid      (cyc_valid),
    .cyc_addr       (cyc_addr),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .cfg_wr         (cfg_wr),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdata      (cfg_rdata),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .cyc_stall      (cyc_stall),
    .switch_err     (switch_err)
  );

  initial hsclk_in = 1'b0;
  always #5 hsclk_in = ~hsclk_in;

  task automatic tick();
    @(posedge hsclk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cyc(input logic [23:0] addr);
    cyc_valid = 1'b1;
    cyc_addr  = addr;
    tick();
    cyc_valid = 1'b0;
  endtask

  task automatic wr_cfg(input logic [7:0] d);
    cfg_wr    = 1'b1;
    cfg_wdata = d;
    tick();
    cfg_wr    = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; cyc_valid = 1'b0; cyc_addr = '0; hsclk_selected = 1'b0;
    lsclk_selected = 1'b0; cfg_wr = 1'b0; cfg_wdata = '0;
    ticks(3);
    n_total++; if (hsclk_sel !== 1'b0) $display("FAIL reset_hsclk_sel got %b exp 0", hsclk_sel); else n_pass++;
    n_total++; if (cpuclk_div_sel !== 2'b00) $display("FAIL reset_div got %b exp 00", cpuclk_div_sel); else n_pass++;
    n_total++; if (cyc_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", cyc_stall); else n_pass++;
    n_total++; if (switch_err !== 1'b0) $display("FAIL reset_err got %b exp 0", switch_err); else n_pass++;
    n_total++; if (cfg_rdata !== 8'h20) $display("FAIL reset_cfg got %h exp 20", cfg_rdata); else n_pass++;
    #2 rst_b = 1'b1;
    tick();
  endtask

  task automatic test_fast_switch();
    wr_cfg(8'h01);
    n_total++; if (cfg_rdata !== 8'h01) $display("FAIL fs_cfg got %h exp 01", cfg_rdata); else n_pass++;
    cyc(24'h000100);
    n_total++; if (hsclk_sel !== 1'b1) $display("FAIL fs_sel got %b exp 1", hsclk_sel); else n_pass++;
    n_total++; if (cyc_stall !== 1'b1) $display("FAIL fs_stall got %b exp 1", cyc_stall); else n_pass++;
    hsclk_selected = 1'b1;
    ticks(2);
    n_total++; if (cyc_stall !== 1'b1) $display("FAIL fs_stall_sync got %b exp 1", cyc_stall); else n_pass++;
    tick();
    n_total++; if (cyc_stall !== 1'b0) $display("FAIL fs_stall_drop got %b exp 0", cyc_stall); else n_pass++;
    n_total++; if (switch_err !== 1'b0) $display("FAIL fs_err got %b exp 0", switch_err); else n_pass++;
  endtask

  task automatic test_slow_hold();
    cyc(24'hFF0040);
    n_total++; if (hsclk_sel !== 1'b0) $display("FAIL sh_sel got %b exp 0", hsclk_sel); else n_pass++;
    n_total++; if (cyc_stall !== 1'b1) $display("FAIL sh_stall got %b exp 1", cyc_stall); else n_pass++;
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    ticks(3);
    n_total++; if (cyc_stall !== 1'b0) $display("FAIL sh_stall_drop got %b exp 0", cyc_stall); else n_pass++;
    wr_cfg(8'h19);
    cyc(24'hFF0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      cyc(24'h000200);
      n_total++;
      if (hsclk_sel !== 1'b0 || cyc_stall !== 1'b0)
        $display("FAIL sh_hold%0d got sel=%b stall=%b exp sel=0 stall=0", k, hsclk_sel, cyc_stall);
      else n_pass++;
    end
    tick();
    cyc(24'h000200);
    n_total++;
    if (hsclk_sel !== 1'b1 || cyc_stall !== 1'b1)
      $display("FAIL sh_fourth got sel=%b stall=%b exp sel=1 stall=1", hsclk_sel, cyc_stall);
    else n_pass++;
  endtask

  // Entered directly from test_slow_hold: TO_FAST with hsclk_selected low.
  task automatic test_timeout();
    ticks(254);
    n_total++;
    if (cyc_stall !== 1'b1 || switch_err !== 1'b0)
      $display("FAIL to_before got stall=%b err=%b exp stall=1 err=0", cyc_stall, switch_err);
    else n_pass++;
    tick();
    n_total++; if (switch_err !== 1'b1) $display("FAIL to_err got %b exp 1", switch_err); else n_pass++;
    n_total++; if (cyc_stall !== 1'b0) $display("FAIL to_stall got %b exp 0", cyc_stall); else n_pass++;
    n_total++; if (hsclk_sel !== 1'b1) $display("FAIL to_sel got %b exp 1", hsclk_sel); else n_pass++;
    wr_cfg(8'h01);
    n_total++; if (switch_err !== 1'b0) $display("FAIL to_clear got %b exp 0", switch_err); else n_pass++;
    hsclk_selected = 1'b1;
    lsclk_selected = 1'b0;
    ticks(3);
  endtask

  task automatic test_div_stage();
    wr_cfg(8'h05);
    ticks(2);
    n_total++; if (cpuclk_div_sel !== 2'b00) $display("FAIL dv_fast got %b exp 00", cpuclk_div_sel); else n_pass++;
    cyc(24'hFF0000);
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    ticks(3);
    n_total++; if (cyc_stall !== 1'b0) $display("FAIL dv_stall got %b exp 0", cyc_stall); else n_pass++;
    n_total++; if (cpuclk_div_sel !== 2'b00) $display("FAIL dv_entry got %b exp 00", cpuclk_div_sel); else n_pass++;
    tick();
    n_total++; if (cpuclk_div_sel !== 2'b10) $display("FAIL dv_slow got %b exp 10", cpuclk_div_sel); else n_pass++;
  endtask

  task automatic test_cfg_same_cycle();
    cyc(24'h000100);
    hsclk_selected = 1'b1;
    lsclk_selected = 1'b0;
    ticks(3);
    n_total++; if (cyc_stall !== 1'b0 || hsclk_sel !== 1'b1)
      $display("FAIL cs_fast got stall=%b sel=%b exp stall=0 sel=1", cyc_stall, hsclk_sel); else n_pass++;
    cfg_wr = 1'b1; cfg_wdata = 8'h00; cyc_valid = 1'b1; cyc_addr = 24'h000100;
    tick();
    cfg_wr = 1'b0; cyc_valid = 1'b0;
    n_total++; if (hsclk_sel !== 1'b1 || cyc_stall !== 1'b0)
      $display("FAIL cs_stay got sel=%b stall=%b exp sel=1 stall=0", hsclk_sel, cyc_stall); else n_pass++;
    n_total++; if (cfg_rdata !== 8'h00) $display("FAIL cs_cfg got %h exp 00", cfg_rdata); else n_pass++;
    n_total++; if (cpuclk_div_sel !== 2'b10) $display("FAIL cs_div got %b exp 10", cpuclk_div_sel); else n_pass++;
    tick();
    cyc(24'h000100);
    n_total++; if (hsclk_sel !== 1'b0 || cyc_stall !== 1'b1)
      $display("FAIL cs_toslow got sel=%b stall=%b exp sel=0 stall=1", hsclk_sel, cyc_stall); else n_pass++;
  endtask

  // Still in TO_SLOW from the previous task (lsclk_selected low).
  task automatic test_back_to_back();
    n_total++; if (switch_err !== 1'b0) $display("FAIL bb_pre got %b exp 0", switch_err); else n_pass++;
    cyc(24'h000300);
    n_total++; if (switch_err !== 1'b1) $display("FAIL bb_err got %b exp 1", switch_err); else n_pass++;
    n_total++; if (cyc_stall !== 1'b1) $display("FAIL bb_stall got %b exp 1", cyc_stall); else n_pass++;
  endtask

  task automatic test_async_reset();
    #2 rst_b = 1'b0;
    #1;
    n_total++; if (hsclk_sel !== 1'b0) $display("FAIL ar_sel got %b exp 0", hsclk_sel); else n_pass++;
    n_total++; if (cyc_stall !== 1'b0) $display("FAIL ar_stall got %b exp 0", cyc_stall); else n_pass++;
    n_total++; if (switch_err !== 1'b0) $display("FAIL ar_err got %b exp 0", switch_err); else n_pass++;
    n_total++; if (cpuclk_div_sel !== 2'b00) $display("FAIL ar_div got %b exp 00", cpuclk_div_sel); else n_pass++;
    n_total++; if (cfg_rdata !== 8'h20) $display("FAIL ar_cfg got %h exp 20", cfg_rdata); else n_pass++;
    tick();
    rst_b = 1'b1;
    ticks(2);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_fast_switch();
    test_slow_hold();
    test_timeout();
    test_div_stage();
    test_cfg_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
